// File: rtl/onehot_decoder_2to4.sv
// -----------------------------------------------------------------------------
// onehot_decoder_2to4
//
// Purpose:
//   Decodes a 2-bit binary code from an upstream 4-to-2 encoder back into a
//   one-hot word. Beats arrive through a valid/ready handshake. Each decoded
//   word is buffered in a 2-entry FIFO, and the output side is a valid/ready
//   stream driven from the registered FIFO head. Beats that the encoder flagged
//   as invalid are dropped and counted in a saturating error counter.
//
//   A three-state controller gates acceptance:
//     IDLE  : nothing accepted; waits for En.
//     RUN   : accepts beats while En is high.
//     FLUSH : En dropped with data still queued; the FIFO drains to the output.
//             If En returns, the queued contents are kept and RUN resumes.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   En         in   1      decoder enable; low stops acceptance of new codes
//   Din        in   2      binary code from the encoder
//   Din_err    in   1      encoder flagged this beat as invalid
//   in_valid   in   1      Din/Din_err valid this cycle
//   in_ready   out  1      block accepts a beat this cycle
//   Do         out  4      one-hot word at the FIFO head (0 when empty)
//   out_valid  out  1      Do valid
//   out_ready  in   1      downstream accepts Do
//   err_cnt    out  CNT_W  saturating count of accepted error beats
//   busy       out  1      high while in FLUSH
// -----------------------------------------------------------------------------
module onehot_decoder_2to4 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic [1:0]       Din,
  input  logic             Din_err,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       Do,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int unsigned DEPTH = 2;

  // Binary code to one-hot word.
  function automatic logic [3:0] f_decode(input logic [1:0] code);
    logic [3:0] word;
    word = 4'b0000;
    word[code] = 1'b1;
    return word;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and handshake wires
  // ---------------------------------------------------------------------------
  state_e           r_state;
  state_e           w_state_nxt;

  logic [3:0]       r_mem [DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [1:0]       w_count_nxt;

  logic [CNT_W-1:0] r_err_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_accept;
  logic             w_push;
  logic             w_err_beat;
  logic             w_in_ready;
  logic             w_busy;

  assign w_full  = (r_count == 2'd2);
  assign w_empty = (r_count == 2'd0);

  // The head leaves on any edge where it is valid and downstream is ready.
  assign w_pop = !w_empty && out_ready;

  // A full FIFO can still take a beat when the head leaves on the same edge,
  // which is what sustains one beat per cycle.
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    unique case (r_state)
      ST_RUN:   w_in_ready = En && (!w_full || w_pop);
      ST_FLUSH: w_busy     = 1'b1;
      default:  ;
    endcase
  end

  assign w_accept   = in_valid && w_in_ready;
  // Error beats complete the handshake but never enter the FIFO.
  assign w_push     = w_accept && !Din_err;
  assign w_err_beat = w_accept &&  Din_err;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking assignments so that all
  // registers sample the same pre-edge values; the combinational blocks use
  // blocking assignments and give each target a default first so that no
  // latch is inferred on an unlisted path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (En) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!En) w_state_nxt = w_empty ? ST_IDLE : ST_FLUSH;
      end
      ST_FLUSH: begin
        // Re-enabling takes priority over finishing the drain; the queued
        // words stay put and go out in their original order.
        if (En)                        w_state_nxt = ST_RUN;
        else if (w_count_nxt == 2'd0)  w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
    end
  end

  // NOTE: the storage array has no reset. Reset clears the occupancy count,
  // and Do is masked by out_valid, so stale words can never be observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= f_decode(Din);
  end

  // ---------------------------------------------------------------------------
  // Error counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_err_beat && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Do depends only on registers, so there is no path from Din to Do, and it
  // drops to zero as soon as reset clears the count, without waiting for clk.
  assign out_valid = !w_empty;
  assign Do        = w_empty ? 4'b0000 : r_mem[r_rd_ptr];
  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign err_cnt   = r_err_cnt;

  // ---------------------------------------------------------------------------
  // Internal consistency checks
  // ---------------------------------------------------------------------------
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= 2'd2);

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full && !w_pop));

  a_do_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> $onehot(Do));

  a_no_accept_outside_run : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != ST_RUN) |-> !in_ready);

endmodule
